// File: rtl/muldiv_seq_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_seq_unit_pkg
// Purpose  : Shared definitions for the sequential multiply/divide unit:
//            op encodings, FSM state type, divide-by-zero quotient fill and
//            an op decoder.
// Revision : 1.0 - initial release
// ============================================================================
package muldiv_seq_unit_pkg;

  localparam logic [1:0] OP_MUL  = 2'b00;
  localparam logic [1:0] OP_MULU = 2'b01;
  localparam logic [1:0] OP_DIV  = 2'b10;
  localparam logic [1:0] OP_DIVU = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Quotient on divide-by-zero is all ones; replicated to WIDTH by users.
  localparam logic DIV0_Q_FILL = 1'b1;

  typedef struct packed {
    logic is_div;
    logic is_signed;
  } op_flags_t;

  function automatic op_flags_t op_decode(input logic [1:0] op);
    op_flags_t f;
    f = '0;
    case (op)
      OP_MUL:  begin f.is_div = 1'b0; f.is_signed = 1'b1; end
      OP_MULU: begin f.is_div = 1'b0; f.is_signed = 1'b0; end
      OP_DIV:  begin f.is_div = 1'b1; f.is_signed = 1'b1; end
      OP_DIVU: begin f.is_div = 1'b1; f.is_signed = 1'b0; end
      default: f = '0;
    endcase
    return f;
  endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_seq_unit_sign_fix.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_sign_fix
// Purpose  : Combinational sign handling shared by multiply and divide.
//            Accept side: converts raw operands to unsigned magnitudes and
//            reports which results must be negated.
//            Fix side: negates the unsigned double-width result as needed.
// Ports    : i_op            operation code (accept side)
//            i_a, i_b        raw operands
//            o_mag_a/o_mag_b operand magnitudes
//            o_neg_q         product / quotient must be negated
//            o_neg_r         remainder must be negated (dividend sign)
//            i_fix_div       latched op is a divide
//            i_fix_neg_q/r   latched negate flags
//            i_res / o_res   unsigned result {hi,lo} / sign-corrected result
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_sign_fix #(
  parameter int WIDTH = 32
) (
  input  logic [1:0]         i_op,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  output logic [WIDTH-1:0]   o_mag_a,
  output logic [WIDTH-1:0]   o_mag_b,
  output logic               o_neg_q,
  output logic               o_neg_r,
  input  logic               i_fix_div,
  input  logic               i_fix_neg_q,
  input  logic               i_fix_neg_r,
  input  logic [2*WIDTH-1:0] i_res,
  output logic [2*WIDTH-1:0] o_res
);
  import muldiv_seq_unit_pkg::*;

  op_flags_t        w_flags;
  logic             w_sign_a;
  logic             w_sign_b;
  logic [WIDTH-1:0] w_res_hi;
  logic [WIDTH-1:0] w_res_lo;

  assign w_flags  = op_decode(i_op);
  assign w_sign_a = w_flags.is_signed & i_a[WIDTH-1];
  assign w_sign_b = w_flags.is_signed & i_b[WIDTH-1];

  // The most-negative value maps onto itself, which read as unsigned is the
  // correct magnitude 2^(WIDTH-1).
  assign o_mag_a = w_sign_a ? -i_a : i_a;
  assign o_mag_b = w_sign_b ? -i_b : i_b;

  // Negating a zero result yields zero, so no explicit zero test is needed.
  assign o_neg_q = w_sign_a ^ w_sign_b;
  assign o_neg_r = w_sign_a;

  assign w_res_hi = i_res[2*WIDTH-1:WIDTH];
  assign w_res_lo = i_res[WIDTH-1:0];

  always_comb begin
    o_res = i_res;
    if (i_fix_div) begin
      o_res[WIDTH-1:0]       = i_fix_neg_q ? -w_res_lo : w_res_lo;
      o_res[2*WIDTH-1:WIDTH] = i_fix_neg_r ? -w_res_hi : w_res_hi;
    end else if (i_fix_neg_q) begin
      o_res = -i_res;
    end
  end

endmodule
`default_nettype wire

// File: rtl/muldiv_seq_unit.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_seq_unit
// Purpose  : Multi-cycle signed/unsigned multiply and divide with a double
//            width HI/LO result and fixed WIDTH+2 cycle latency.
// Ports    : clk, clr           clock, synchronous active-high reset
//            start, op          request and operation (sampled when idle)
//            a_in, b_in         multiplicand/dividend, multiplier/divisor
//            busy, done         in-flight flag, one-cycle completion pulse
//            div_by_zero        divide with zero divisor (held)
//            c_lo_out, c_hi_out product lo/hi or quotient/remainder
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_seq_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] c_lo_out,
  output logic [WIDTH-1:0] c_hi_out
);
  import muldiv_seq_unit_pkg::*;

  localparam int                 c_CNT_W    = $clog2(WIDTH + 1);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(WIDTH - 1);

  state_e               r_state;
  logic [c_CNT_W-1:0]   r_cnt;
  logic [2*WIDTH:0]     r_acc;
  logic [WIDTH-1:0]     r_mb;
  logic [WIDTH-1:0]     r_a;
  logic                 r_is_div;
  logic                 r_neg_q;
  logic                 r_neg_r;
  logic                 r_zero;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_dbz;
  logic [WIDTH-1:0]     r_lo;
  logic [WIDTH-1:0]     r_hi;

  op_flags_t            w_flags;
  logic                 w_div_zero;
  logic [WIDTH-1:0]     w_mag_a;
  logic [WIDTH-1:0]     w_mag_b;
  logic                 w_neg_q;
  logic                 w_neg_r;
  logic [2*WIDTH-1:0]   w_fixed;
  logic [WIDTH:0]       w_mul_sum;
  logic [2*WIDTH:0]     w_mul_next;
  logic [2*WIDTH:0]     w_div_shift;
  logic [WIDTH+1:0]     w_div_diff;
  logic [2*WIDTH:0]     w_div_next;

  assign w_flags    = op_decode(op);
  assign w_div_zero = w_flags.is_div && (b_in == '0);

  muldiv_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
    .i_op        (op),
    .i_a         (a_in),
    .i_b         (b_in),
    .o_mag_a     (w_mag_a),
    .o_mag_b     (w_mag_b),
    .o_neg_q     (w_neg_q),
    .o_neg_r     (w_neg_r),
    .i_fix_div   (r_is_div),
    .i_fix_neg_q (r_neg_q),
    .i_fix_neg_r (r_neg_r),
    .i_res       (r_acc[2*WIDTH-1:0]),
    .o_res       (w_fixed)
  );

  // Multiply step: accumulator = {partial product hi, remaining multiplier}.
  // Add the multiplicand magnitude into the upper half when the multiplier
  // LSB is set, then shift the whole accumulator right by one.
  assign w_mul_sum  = r_acc[2*WIDTH:WIDTH] + {1'b0, (r_acc[0] ? r_mb : '0)};
  assign w_mul_next = {1'b0, w_mul_sum, r_acc[WIDTH-1:1]};

  // Restoring divide step: accumulator = {partial remainder, dividend bits
  // being shifted out / quotient bits being shifted in}.
  assign w_div_shift = {r_acc[2*WIDTH-1:0], 1'b0};
  assign w_div_diff  = {1'b0, w_div_shift[2*WIDTH:WIDTH]} - {2'b00, r_mb};
  assign w_div_next  = w_div_diff[WIDTH+1] ? w_div_shift
                     : {w_div_diff[WIDTH:0], w_div_shift[WIDTH-1:1], 1'b1};

  always_ff @(posedge clk) begin
    if (clr) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mb     <= '0;
      r_a      <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_zero   <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_dbz    <= 1'b0;
      r_lo     <= '0;
      r_hi     <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE, ST_DONE: begin
          r_state <= ST_IDLE;
          if (start) begin
            r_a      <= a_in;
            r_mb     <= w_mag_b;
            r_acc    <= {{(WIDTH+1){1'b0}}, w_mag_a};
            r_is_div <= w_flags.is_div;
            r_neg_q  <= w_neg_q;
            r_neg_r  <= w_neg_r & w_flags.is_div;
            r_zero   <= w_div_zero;
            r_cnt    <= '0;
            r_busy   <= 1'b1;
            r_dbz    <= 1'b0;
            // A zero divisor skips the iteration but still passes through
            // FIX so done lands two cycles after acceptance.
            r_state  <= w_div_zero ? ST_FIX : ST_RUN;
          end
        end
        ST_RUN: begin
          r_acc <= r_is_div ? w_div_next : w_mul_next;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == c_CNT_LAST) begin
            r_state <= ST_FIX;
          end
        end
        ST_FIX: begin
          if (r_zero) begin
            r_lo  <= {WIDTH{DIV0_Q_FILL}};
            r_hi  <= r_a;
            r_dbz <= 1'b1;
          end else begin
            r_lo  <= w_fixed[WIDTH-1:0];
            r_hi  <= w_fixed[2*WIDTH-1:WIDTH];
          end
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= ST_DONE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign div_by_zero = r_dbz;
  assign c_lo_out    = r_lo;
  assign c_hi_out    = r_hi;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_seq_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_muldiv_seq_unit
// Purpose  : Self-checking bench for muldiv_seq_unit (WIDTH=32): directed
//            vector table plus hand-written multi-cycle sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_muldiv_seq_unit;
  import muldiv_seq_unit_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         clr;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         busy;
  logic         done;
  logic         div_by_zero;
  logic [W-1:0] c_lo_out;
  logic [W-1:0] c_hi_out;

  int n_checks = 0;
  int n_err    = 0;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    int          lat;
  } vec_t;

  vec_t vecs[13];
  vec_t vh;

  muldiv_seq_unit #(.WIDTH(W)) dut (
    .clk         (clk),
    .clr         (clr),
    .start       (start),
    .op          (op),
    .a_in        (a_in),
    .b_in        (b_in),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .c_lo_out    (c_lo_out),
    .c_hi_out    (c_hi_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Call at a negedge; start is seen at the following posedge (edge k),
  // after which operands are scrambled to show they were latched.
  task automatic issue(input vec_t v);
    op    = v.op;
    a_in  = v.a;
    b_in  = v.b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a_in  = $urandom;
    b_in  = $urandom;
    op    = 2'($urandom);
  endtask

  // Walks negedges after acceptance until done; returns positioned on the
  // negedge where done is high. poke>0 pulses a competing start mid-RUN.
  task automatic wait_done(input vec_t v, input string tag, input int poke);
    int   lat     = -1;
    logic busy_ok = 1'b1;
    for (int n = 1; n <= v.lat + 10; n++) begin
      @(negedge clk);
      if (n == 1) chk({tag, "_dbz_clr"}, {63'd0, div_by_zero}, 64'd0);
      if (done) begin
        lat = n;
        break;
      end
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (poke > 0 && n == poke) begin
        start = 1'b1;
        op    = OP_DIVU;
        a_in  = 32'd1000;
        b_in  = 32'd3;
      end
      if (poke > 0 && n == poke + 1) start = 1'b0;
    end
    chk({tag, "_latency"},  64'(lat), 64'(v.lat));
    chk({tag, "_busy_run"}, {63'd0, busy_ok}, 64'd1);
    chk({tag, "_busy_done"}, {63'd0, busy}, 64'd0);
    chk({tag, "_hi"}, {32'd0, c_hi_out}, {32'd0, v.hi});
    chk({tag, "_lo"}, {32'd0, c_lo_out}, {32'd0, v.lo});
    chk({tag, "_dbz"}, {63'd0, div_by_zero}, {63'd0, v.dbz});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int extra;

    clr   = 1'b1;
    start = 1'b0;
    op    = OP_MUL;
    a_in  = '0;
    b_in  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_dbz",  {63'd0, div_by_zero}, 64'd0);
    chk("rst_hi",   {32'd0, c_hi_out}, 64'd0);
    chk("rst_lo",   {32'd0, c_lo_out}, 64'd0);
    clr = 1'b0;

    vecs[0]  = '{OP_MUL,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 34};
    vecs[1]  = '{OP_MULU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 34};
    vecs[2]  = '{OP_MUL,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0, 34};
    vecs[3]  = '{OP_DIV,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 34};
    vecs[4]  = '{OP_DIVU, 32'hFFFFFFF9, 32'd2,        32'h00000001, 32'h7FFFFFFC, 1'b0, 34};
    vecs[5]  = '{OP_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 34};
    vecs[6]  = '{OP_DIVU, 32'h00001234, 32'd0,        32'h00001234, 32'hFFFFFFFF, 1'b1, 2};
    vecs[7]  = '{OP_MUL,  32'hFFFFFFFB, 32'd0,        32'h00000000, 32'h00000000, 1'b0, 34};
    vecs[8]  = '{OP_DIV,  32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, 34};
    vecs[9]  = '{OP_DIV,  32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003, 1'b0, 34};
    vecs[10] = '{OP_MULU, 32'h80000000, 32'd2,        32'h00000001, 32'h00000000, 1'b0, 34};
    vecs[11] = '{OP_DIV,  32'd5,        32'd0,        32'h00000005, 32'hFFFFFFFF, 1'b1, 2};
    vecs[12] = '{OP_DIVU, 32'd100,      32'd7,        32'h00000002, 32'h0000000E, 1'b0, 34};

    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      issue(vecs[i]);
      wait_done(vecs[i], $sformatf("v%0d", i), 0);
      @(negedge clk);
      chk($sformatf("v%0d_done_pulse", i), {63'd0, done}, 64'd0);
      chk($sformatf("v%0d_hold_lo", i), {32'd0, c_lo_out}, {32'd0, vecs[i].lo});
      chk($sformatf("v%0d_hold_dbz", i), {63'd0, div_by_zero}, {63'd0, vecs[i].dbz});
    end

    // Start pulsed during RUN must be ignored: one result, one done.
    vh = '{OP_MUL, 32'd3, 32'd5, 32'd0, 32'd15, 1'b0, 34};
    @(negedge clk);
    issue(vh);
    wait_done(vh, "ign", 5);
    extra = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) extra++;
    end
    chk("ign_no_extra_done", 64'(extra), 64'd0);

    // clr in cycle k+10 aborts: outputs zero, no done pulse.
    vh = '{OP_MULU, 32'd7, 32'd9, 32'd0, 32'd63, 1'b0, 34};
    @(negedge clk);
    issue(vh);
    repeat (10) @(negedge clk);
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_done", {63'd0, done}, 64'd0);
    chk("abort_dbz",  {63'd0, div_by_zero}, 64'd0);
    chk("abort_hi",   {32'd0, c_hi_out}, 64'd0);
    chk("abort_lo",   {32'd0, c_lo_out}, 64'd0);

    // Start right after the clr, then a back-to-back start in its DONE cycle.
    vh = '{OP_MUL, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 34};
    @(negedge clk);
    issue(vh);
    wait_done(vh, "post_clr", 0);
    vh = '{OP_DIVU, 32'd1000, 32'd3, 32'd1, 32'd333, 1'b0, 34};
    issue(vh);
    wait_done(vh, "b2b", 0);

    // clr and start together: start is dropped.
    @(negedge clk);
    clr   = 1'b1;
    start = 1'b1;
    op    = OP_MUL;
    a_in  = 32'd3;
    b_in  = 32'd3;
    @(posedge clk);
    #1;
    clr   = 1'b0;
    start = 1'b0;
    chk("clr_start_busy", {63'd0, busy}, 64'd0);
    extra = 0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) extra++;
    end
    chk("clr_start_idle", 64'(extra), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
`default_nettype wire
